// File: rtl/mda_motor_pwm_gen_if.sv
// Command and PWM output bundle between the motor control registers and the PWM generator.
// The generator is the slave; the register block (or a testbench) is the master.
interface mda_motor_pwm_gen_if #(
    parameter int DUTY_W = 16
);
    logic              cmd_valid;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;
    logic              dir;
    logic              on;
    logic              period_start;
    logic              wdog_tripped;

    modport master (
        output cmd_valid, cmd_duty, cmd_dir,
        input  dir, on, period_start, wdog_tripped
    );

    modport slave (
        input  cmd_valid, cmd_duty, cmd_dir,
        output dir, on, period_start, wdog_tripped
    );
endinterface

// File: rtl/mda_motor_pwm_gen.sv
// Per-motor PWM generator feeding the dead-time/H-bridge stage: shadowed duty updates at
// period boundaries, a one-period off gap on direction reversal and a command watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | normal PWM; shadow copied to active at each boundary
//   GAP   | reversal in progress; one full period with on=0, old dir held
//   TRIP  | watchdog expired; on=0, dir held until the next command
module mda_motor_pwm_gen #(
    parameter int PERIOD_CYCLES = 2500,
    parameter int DUTY_W        = 16,
    parameter int WDOG_PERIODS  = 5000
) (
    input  logic               clk,
    input  logic               reset,
    mda_motor_pwm_gen_if.slave pwm_if
);
    typedef enum logic [1:0] {ST_RUN, ST_GAP, ST_TRIP} state_t;

    localparam logic [15:0]       CNT_LAST  = 16'(PERIOD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PERIOD_CYCLES);
    localparam logic [31:0]       WDOG_LIM  = 32'(WDOG_PERIODS);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DUTY_W-1:0] sh_duty_q, sh_duty_d;
    logic              sh_dir_q, sh_dir_d;
    logic [DUTY_W-1:0] act_duty_q, act_duty_d;
    logic              act_dir_q, act_dir_d;
    logic [31:0]       wcnt_q, wcnt_d;
    logic              on_q, on_d;
    logic              ps_q, ps_d;

    logic              cnt_last;
    logic              wdog_expire;
    logic [DUTY_W-1:0] duty_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            sh_duty_q  <= '0;
            sh_dir_q   <= 1'b0;
            act_duty_q <= '0;
            act_dir_q  <= 1'b0;
            wcnt_q     <= '0;
            on_q       <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_duty_q  <= sh_duty_d;
            sh_dir_q   <= sh_dir_d;
            act_duty_q <= act_duty_d;
            act_dir_q  <= act_dir_d;
            wcnt_q     <= wcnt_d;
            on_q       <= on_d;
            ps_q       <= ps_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_duty_d  = sh_duty_q;
        sh_dir_d   = sh_dir_q;
        act_duty_d = act_duty_q;
        act_dir_d  = act_dir_q;

        cnt_last = (cnt_q == CNT_LAST);
        cnt_d    = cnt_last ? 16'd0 : cnt_q + 16'd1;

        duty_sat = (32'(pwm_if.cmd_duty) > 32'(PERIOD_CYCLES)) ? DUTY_FULL : pwm_if.cmd_duty;

        if (pwm_if.cmd_valid) begin
            sh_duty_d = duty_sat;
            sh_dir_d  = pwm_if.cmd_dir;
        end

        // A command always wins over the boundary increment; the count saturates at the limit.
        if (pwm_if.cmd_valid) begin
            wcnt_d = '0;
        end else if (cnt_last && (wcnt_q != WDOG_LIM)) begin
            wcnt_d = wcnt_q + 32'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
        wdog_expire = (WDOG_PERIODS != 0) && !pwm_if.cmd_valid && (wcnt_d == WDOG_LIM);

        case (state_q)
            ST_TRIP: begin
                if (pwm_if.cmd_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_GAP: begin
                if (wdog_expire) begin
                    state_d    = ST_TRIP;
                    act_duty_d = '0;
                end else if (cnt_last) begin
                    state_d    = ST_RUN;
                    act_duty_d = sh_duty_q;
                    act_dir_d  = sh_dir_q;
                end
            end
            ST_RUN: begin
                if (wdog_expire) begin
                    state_d    = ST_TRIP;
                    act_duty_d = '0;
                end else if (cnt_last) begin
                    // Reversing a driven motor: spend one period off before dir may change.
                    if ((sh_dir_q != act_dir_q) && (act_duty_q != '0)) begin
                        state_d    = ST_GAP;
                        act_duty_d = '0;
                    end else begin
                        act_duty_d = sh_duty_q;
                        act_dir_d  = sh_dir_q;
                    end
                end
            end
            default: begin
                state_d    = ST_RUN;
                act_duty_d = '0;
            end
        endcase

        on_d = (state_q == ST_RUN) && (32'(cnt_q) < 32'(act_duty_q));
        ps_d = (cnt_q == 16'd0);
    end

    assign pwm_if.on           = on_q;
    assign pwm_if.dir          = act_dir_q;
    assign pwm_if.period_start = ps_q;
    assign pwm_if.wdog_tripped = (state_q == ST_TRIP);
endmodule

// File: tb/tb_mda_motor_pwm_gen.sv
// Bench for mda_motor_pwm_gen: a per-cycle behavioural model checked every cycle, directed
// scenarios with hand-computed pulse counts, then randomized command traffic.
module tb_mda_motor_pwm_gen;
    localparam int P  = 100;
    localparam int W  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mda_motor_pwm_gen_if #(.DUTY_W(DW)) bus ();

    mda_motor_pwm_gen #(.PERIOD_CYCLES(P), .DUTY_W(DW), .WDOG_PERIODS(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_if (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = driving, 1 = reversal gap, 2 = watchdog tripped.
    int   m_cnt = 0, m_sh_duty = 0, m_duty = 0, m_w = 0, m_mode = 0;
    logic m_sh_dir = 1'b0, m_dir = 1'b0;
    logic exp_on, exp_dir, exp_ps, exp_trip;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event time=%0t", name, $time);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_sh_duty = 0; m_duty = 0; m_w = 0; m_mode = 0;
            m_sh_dir = 1'b0; m_dir = 1'b0;
            exp_on = 1'b0; exp_dir = 1'b0; exp_ps = 1'b0; exp_trip = 1'b0;
        end else begin
            bit v, bd, expire;
            int d, nw;
            v  = bus.cmd_valid;
            d  = int'(bus.cmd_duty);
            if (d > P) d = P;
            bd = (m_cnt == P - 1);
            exp_on = (m_mode == 0) && (m_cnt < m_duty);
            exp_ps = (m_cnt == 0);
            nw = v ? 0 : ((bd && m_w < W) ? m_w + 1 : m_w);
            expire = !v && (nw >= W);
            if (m_mode == 2) begin
                if (v) m_mode = 0;
            end else if (expire) begin
                m_mode = 2;
                m_duty = 0;
            end else if (bd) begin
                if (m_mode == 0 && m_sh_dir != m_dir && m_duty != 0) begin
                    m_mode = 1;
                    m_duty = 0;
                end else begin
                    m_mode = 0;
                    m_duty = m_sh_duty;
                    m_dir  = m_sh_dir;
                end
            end
            if (v) begin
                m_sh_duty = d;
                m_sh_dir  = bus.cmd_dir;
            end
            m_cnt = bd ? 0 : m_cnt + 1;
            m_w   = nw;
            exp_dir  = m_dir;
            exp_trip = (m_mode == 2);
        end
        #1;
        check("on", int'(bus.on), int'(exp_on));
        check("dir", int'(bus.dir), int'(exp_dir));
        check("period_start", int'(bus.period_start), int'(exp_ps));
        check("wdog_tripped", int'(bus.wdog_tripped), int'(exp_trip));
    end

    task automatic send(input int duty, input logic dir);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_duty  = DW'(duty);
        bus.cmd_dir   = dir;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int k);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (m_cnt != k && g < 300);
        if (m_cnt != k) timeout("wait_cnt");
    endtask

    // Skips to the next period_start, then counts on over that full period.
    task automatic period(output int npre, output int pre_on, output int ones, output int dir0);
        npre = 0; pre_on = 0; ones = 0; dir0 = 0;
        forever begin
            @(posedge clk); #2;
            if (bus.period_start) break;
            npre++;
            pre_on += int'(bus.on);
            if (npre > 300) begin
                timeout("period_start");
                break;
            end
        end
        dir0 = int'(bus.dir);
        ones = int'(bus.on);
        for (int i = 1; i < P; i++) begin
            @(posedge clk); #2;
            ones += int'(bus.on);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int npre, pre_on, ones, dir0;
        bus.cmd_valid = 1'b0;
        bus.cmd_duty  = '0;
        bus.cmd_dir   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_on", int'(bus.on), 0);
        check("reset_trip", int'(bus.wdog_tripped), 0);
        reset = 1'b0;

        // 1: first command mid-period
        wait_cnt(50);
        send(25, 1'b0);
        period(npre, pre_on, ones, dir0);
        check("t1_current_on", pre_on, 0);
        check("t1_width", ones, 25);
        period(npre, pre_on, ones, dir0);
        check("t1_width2", ones, 25);

        // 2: two writes inside one period, last one wins
        fork
            period(npre, pre_on, ones, dir0);
            begin
                wait_cnt(10); send(60, 1'b0);
                wait_cnt(50); send(40, 1'b0);
            end
        join
        check("t2_no_glitch", ones, 25);
        period(npre, pre_on, ones, dir0);
        check("t2_last_wins", ones, 40);

        // 3: reversal with nonzero duty, then with zero duty
        send(50, 1'b0);
        period(npre, pre_on, ones, dir0);
        check("t3_width50", ones, 50);
        send(50, 1'b1);
        period(npre, pre_on, ones, dir0);
        check("t3_gap_on", ones, 0);
        check("t3_gap_dir", dir0, 0);
        period(npre, pre_on, ones, dir0);
        check("t3_after_gap_on", ones, 50);
        check("t3_after_gap_dir", dir0, 1);
        send(0, 1'b1);
        period(npre, pre_on, ones, dir0);
        check("t3_zero_duty", ones, 0);
        send(30, 1'b0);
        period(npre, pre_on, ones, dir0);
        check("t3_direct_on", ones, 30);
        check("t3_direct_dir", dir0, 0);

        // 4: saturation and zero duty
        send(200, 1'b0);
        period(npre, pre_on, ones, dir0);
        check("t4_full", ones, 100);
        send(0, 1'b0);
        period(npre, pre_on, ones, dir0);
        check("t4_zero", ones, 0);

        // 5: watchdog trip and recovery
        send(30, 1'b1);
        period(npre, pre_on, ones, dir0);
        check("t5_p1", ones, 30);
        period(npre, pre_on, ones, dir0);
        check("t5_p2", ones, 30);
        period(npre, pre_on, ones, dir0);
        check("t5_p3", ones, 30);
        check("t5_tripped", int'(bus.wdog_tripped), 1);
        check("t5_dir_held", int'(bus.dir), 1);
        period(npre, pre_on, ones, dir0);
        check("t5_trip_on", ones, 0);
        check("t5_still_tripped", int'(bus.wdog_tripped), 1);
        send(30, 1'b1);
        check("t5_cleared", int'(bus.wdog_tripped), 0);
        period(npre, pre_on, ones, dir0);
        check("t5_resume", ones, 30);

        // 6: reset while driving
        send(80, 1'b1);
        period(npre, pre_on, ones, dir0);
        check("t6_width80", ones, 80);
        wait_cnt(40);
        check("t6_on_before", int'(bus.on), 1);
        check("t6_dir_before", int'(bus.dir), 1);
        reset = 1'b1;
        #1;
        check("t6_on_async", int'(bus.on), 0);
        check("t6_dir_async", int'(bus.dir), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        period(npre, pre_on, ones, dir0);
        check("t6_first_ps", npre, 0);
        check("t6_no_cmd_on", ones, 0);
        period(npre, pre_on, ones, dir0);
        check("t6_no_cmd_on2", ones, 0);

        // randomized traffic, including boundary-cycle writes and watchdog trips
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.cmd_valid = ($urandom_range(0, 199) == 0) ||
                            (m_cnt == P - 1 && $urandom_range(0, 7) == 0);
            bus.cmd_duty  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 110));
            bus.cmd_dir   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
